mailbox_arbiter: RTL and testbench
==================================

MAILBOX_ARBITER -- requirements
Module: mailbox_arbiter

Interface
REQ-001 C7M  in  1  sole clock; all state changes on rising edge.
REQ-002 nRES  in  1  reset, asynchronous, active-low.
REQ-003 AWrStb  in  1  6502 write strobe, one C7M cycle, pre-qualified (DEVSEL, S5).
REQ-004 ARdStb  in  1  6502 read strobe, one C7M cycle, pre-qualified.
REQ-005 ASel  in  4  6502 register select (A[3:0]).
REQ-006 ADin  in  8  6502 write data.
REQ-007 ADout  out  8  6502 read data, combinational from ASel and state.
REQ-008 RWrStb, RRdStb  in  1 each  AVR write/read strobes, one C7M cycle each, pre-synchronised.
REQ-009 RSel  in  4  AVR register select (latched RAD[3:0]).
REQ-010 RDin  in  8  AVR write data.
REQ-011 RDout  out  8  AVR read data, combinational from RSel and state.
REQ-012 AIRQ  out  1  active-high interrupt request to 6502 pad logic.
REQ-013 nRIRQ  out  1  active-low interrupt to AVR.

Function
REQ-014 Register map, both ports: 0 status, 1 command, 2 data low, 3 data high; other selects read 8'h00 and ignore writes.
REQ-015 Command FIFO: 4 entries x 7 bits, 3-bit count 0..4, 2-bit wrapping read/write pointers.
REQ-016 6502 write to 1: push ADin[6:0] when count<4; when count==4, discard data and set Ovf sticky flag.
REQ-017 AVR read of 1: RDout={count!=0, head[6:0]}; strobe pops head when count!=0; when empty, RDout=8'h00 and no pop.
REQ-018 Push and pop in same cycle with count in 1..4: both take effect, count unchanged; when count==4 the push succeeds and Ovf is not set.
REQ-019 Push and pop in same cycle with count==0: push succeeds and pop is ignored, so count becomes 1.
REQ-020 6502 status read: ADout={count!=0, Done, Ovf, Coll, 2'b00, AIRQEN, RIRQEN}.
REQ-021 6502 status write: AIRQEN<=ADin[1], RIRQEN<=ADin[0]; ADin[5]=1 clears Ovf; ADin[4]=1 clears Coll.
REQ-022 AVR status write with RDin[0]=1 sets Done; ARdStb on status clears Done after returning Done=1 that cycle.
REQ-023 Done set and clear in same cycle: set wins.
REQ-024 16-bit Data register, byte-writable from both ports; reads return the current byte.
REQ-025 Simultaneous writes to the same Data byte: AVR value stored; Coll flag set.
REQ-026 Simultaneous writes to different Data bytes: both stored; Coll not set.
REQ-027 Sticky flag set and clear in same cycle: set wins.
REQ-028 AIRQ = Done & AIRQEN; nRIRQ = ~((count!=0) & RIRQEN); both combinational from registered state.
REQ-029 Strobes act on the same edge they are sampled; no added latency beyond one C7M edge.

Reset
REQ-030 nRES low, asynchronously: count, pointers, Done, Ovf, Coll, AIRQEN, RIRQEN and Data all go to 0.
REQ-031 During reset: AIRQ=0, nRIRQ=1, FIFO contents don't-care and never visible while count==0.
REQ-032 Reset asserted mid-transfer: any push/pop in progress is discarded; first edge after release is idle.

Structure
REQ-033 Shared package mouserial_pkg: register-select constants (REG_STAT, REG_CMD, REG_DATAL, REG_DATAH), FIFO_DEPTH=4, CMD_W=7, status-bit index constants.
REQ-034 One sub-module cmd_fifo (push, pop, din, head, count, full, empty), instantiated once; arbitration and flags stay in mailbox_arbiter.

Verification
REQ-035 Push 0x11,0x22,0x33,0x44,0x55 from 6502 -> count=4, Ovf=1; AVR pops return 0x91,0xA2,0xB3,0xC4, then 0x00.
REQ-036 With count=4, push 0x7F and pop in the same cycle -> pop returns oldest entry; count stays 4; Ovf stays 0; last pop later returns 0xFF.
REQ-037 Empty FIFO, push 0x05 with simultaneous AVR cmd read -> RDout=0x00; count=1; next pop returns 0x85.
REQ-038 6502 writes 0xAA and AVR writes 0x55 to Data low in the same cycle -> Data low=0x55, Coll=1; 6502 status write 0x10 -> Coll=0.
REQ-039 AIRQEN=1, AVR status write 0x01 -> AIRQ=1; 6502 status read returns bit6=1; AIRQ=0 next cycle; read again returns bit6=0.
REQ-040 Assert nRES between edges with count=3 and Done=1 -> AIRQ=0 and nRIRQ=1 immediately; after release an AVR cmd read returns 0x00.

Source files
------------

// File: rtl/mouserial_pkg.sv
// Shared constants for the 6502/AVR mailbox: register selects, FIFO geometry
// and status-byte bit positions.
package mouserial_pkg;

  localparam int DATA_W     = 8;
  localparam int SEL_W      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CMD_W      = 7;
  localparam int CNT_W      = 3;
  localparam int PTR_W      = 2;

  localparam logic [SEL_W-1:0] REG_STAT  = 4'd0;
  localparam logic [SEL_W-1:0] REG_CMD   = 4'd1;
  localparam logic [SEL_W-1:0] REG_DATAL = 4'd2;
  localparam logic [SEL_W-1:0] REG_DATAH = 4'd3;

  localparam int ST_NE     = 7;
  localparam int ST_DONE   = 6;
  localparam int ST_OVF    = 5;
  localparam int ST_COLL   = 4;
  localparam int ST_AIRQEN = 1;
  localparam int ST_RIRQEN = 0;

  localparam int CTL_CLR_OVF  = 5;
  localparam int CTL_CLR_COLL = 4;
  localparam int CTL_SET_DONE = 0;

  function automatic logic [DATA_W-1:0] pack_status(input logic nonempty,
                                                   input logic done,
                                                   input logic ovf,
                                                   input logic coll,
                                                   input logic airqen,
                                                   input logic rirqen);
    logic [DATA_W-1:0] s;
    s            = '0;
    s[ST_NE]     = nonempty;
    s[ST_DONE]   = done;
    s[ST_OVF]    = ovf;
    s[ST_COLL]   = coll;
    s[ST_AIRQEN] = airqen;
    s[ST_RIRQEN] = rirqen;
    return s;
  endfunction

endpackage

// File: rtl/mailbox_arbiter_if.sv
// Register-bus bundle for both mailbox ports (6502 side A, AVR side R) plus
// the two interrupt lines.
interface mailbox_arbiter_if;
  import mouserial_pkg::*;

  logic              AWrStb;
  logic              ARdStb;
  logic [SEL_W-1:0]  ASel;
  logic [DATA_W-1:0] ADin;
  logic [DATA_W-1:0] ADout;
  logic              RWrStb;
  logic              RRdStb;
  logic [SEL_W-1:0]  RSel;
  logic [DATA_W-1:0] RDin;
  logic [DATA_W-1:0] RDout;
  logic              AIRQ;
  logic              nRIRQ;

  modport master (
    output AWrStb, ARdStb, ASel, ADin,
    output RWrStb, RRdStb, RSel, RDin,
    input  ADout, RDout, AIRQ, nRIRQ
  );

  modport slave (
    input  AWrStb, ARdStb, ASel, ADin,
    input  RWrStb, RRdStb, RSel, RDin,
    output ADout, RDout, AIRQ, nRIRQ
  );

endinterface

// File: rtl/mailbox_arbiter_cmd_fifo.sv
// Four-entry command FIFO. A push into a full FIFO is accepted only when a pop
// frees the head slot on the same edge; a pop of an empty FIFO is ignored.
module cmd_fifo
  import mouserial_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] din,
  output logic [CMD_W-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [CMD_W-1:0] mem_q [FIFO_DEPTH];
  logic [CMD_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never visible while count is zero, so it carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mailbox_arbiter.sv
// Dual-port mailbox between the 6502 bus and the AVR: command FIFO (6502 to AVR),
// shared 16-bit data register, status/handshake flags and both interrupt lines.
module mailbox_arbiter
  import mouserial_pkg::*;
(
  input logic              C7M,
  input logic              nRES,
  mailbox_arbiter_if.slave bus
);

  logic              a_wr_stat, a_rd_stat, a_wr_cmd, a_wr_datal, a_wr_datah;
  logic              r_wr_stat, r_rd_cmd, r_wr_datal, r_wr_datah;
  logic              fifo_full, fifo_empty, push_ok, pop_ok, ovf_set, coll_set;
  logic [CMD_W-1:0]  fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] status_byte;

  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              coll_q, coll_d;
  logic              airqen_q, airqen_d;
  logic              rirqen_q, rirqen_d;
  logic [15:0]       data_q, data_d;

  assign a_wr_stat  = bus.AWrStb & (bus.ASel == REG_STAT);
  assign a_rd_stat  = bus.ARdStb & (bus.ASel == REG_STAT);
  assign a_wr_cmd   = bus.AWrStb & (bus.ASel == REG_CMD);
  assign a_wr_datal = bus.AWrStb & (bus.ASel == REG_DATAL);
  assign a_wr_datah = bus.AWrStb & (bus.ASel == REG_DATAH);
  assign r_wr_stat  = bus.RWrStb & (bus.RSel == REG_STAT);
  assign r_rd_cmd   = bus.RRdStb & (bus.RSel == REG_CMD);
  assign r_wr_datal = bus.RWrStb & (bus.RSel == REG_DATAL);
  assign r_wr_datah = bus.RWrStb & (bus.RSel == REG_DATAH);

  // A push into a full FIFO still lands when the AVR pops on the same edge.
  assign pop_ok   = r_rd_cmd & ~fifo_empty;
  assign push_ok  = a_wr_cmd & (~fifo_full | pop_ok);
  assign ovf_set  = a_wr_cmd & fifo_full & ~pop_ok;
  assign coll_set = (a_wr_datal & r_wr_datal) | (a_wr_datah & r_wr_datah);

  cmd_fifo u_cmd_fifo (
    .clk   (C7M),
    .rst_n (nRES),
    .push  (push_ok),
    .pop   (pop_ok),
    .din   (bus.ADin[CMD_W-1:0]),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Clears are applied first so that a coincident set always wins.
  always_comb begin
    done_d   = done_q;
    ovf_d    = ovf_q;
    coll_d   = coll_q;
    airqen_d = airqen_q;
    rirqen_d = rirqen_q;
    data_d   = data_q;

    if (a_rd_stat) done_d = 1'b0;
    if (r_wr_stat && bus.RDin[CTL_SET_DONE]) done_d = 1'b1;

    if (a_wr_stat) begin
      airqen_d = bus.ADin[ST_AIRQEN];
      rirqen_d = bus.ADin[ST_RIRQEN];
      if (bus.ADin[CTL_CLR_OVF])  ovf_d  = 1'b0;
      if (bus.ADin[CTL_CLR_COLL]) coll_d = 1'b0;
    end
    if (ovf_set)  ovf_d  = 1'b1;
    if (coll_set) coll_d = 1'b1;

    // AVR write is applied last so it owns a byte both ports hit together.
    if (a_wr_datal) data_d[7:0]  = bus.ADin;
    if (a_wr_datah) data_d[15:8] = bus.ADin;
    if (r_wr_datal) data_d[7:0]  = bus.RDin;
    if (r_wr_datah) data_d[15:8] = bus.RDin;
  end

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      coll_q   <= 1'b0;
      airqen_q <= 1'b0;
      rirqen_q <= 1'b0;
      data_q   <= '0;
    end else begin
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      coll_q   <= coll_d;
      airqen_q <= airqen_d;
      rirqen_q <= rirqen_d;
      data_q   <= data_d;
    end
  end

  assign status_byte = pack_status(~fifo_empty, done_q, ovf_q, coll_q,
                                   airqen_q, rirqen_q);

  always_comb begin
    bus.ADout = '0;
    case (bus.ASel)
      REG_STAT:  bus.ADout = status_byte;
      REG_CMD:   bus.ADout = {{(DATA_W-CNT_W){1'b0}}, fifo_count};
      REG_DATAL: bus.ADout = data_q[7:0];
      REG_DATAH: bus.ADout = data_q[15:8];
      default:   bus.ADout = '0;
    endcase
  end

  // The head is masked while empty so stale FIFO storage never leaks out.
  always_comb begin
    bus.RDout = '0;
    case (bus.RSel)
      REG_STAT:  bus.RDout = status_byte;
      REG_CMD:   bus.RDout = fifo_empty ? '0 : {1'b1, fifo_head};
      REG_DATAL: bus.RDout = data_q[7:0];
      REG_DATAH: bus.RDout = data_q[15:8];
      default:   bus.RDout = '0;
    endcase
  end

  assign bus.AIRQ  = done_q & airqen_q;
  assign bus.nRIRQ = ~(~fifo_empty & rirqen_q);

endmodule

// File: tb/tb_mailbox_arbiter.sv
// Directed bench for mailbox_arbiter; a queue tracks the expected command
// stream from 6502 pushes to AVR pops.
module tb_mailbox_arbiter;
  import mouserial_pkg::*;

  logic C7M = 1'b0;
  logic nRES = 1'b0;

  mailbox_arbiter_if bus();

  mailbox_arbiter dut (
    .C7M  (C7M),
    .nRES (nRES),
    .bus  (bus)
  );

  always #5 C7M = ~C7M;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] a_s, r_s;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive after the falling edge, sample read data before the
  // rising edge, drop strobes just after it.
  task automatic cyc(input logic aw, input logic ar, input logic [3:0] asel,
                     input logic [7:0] adin, input logic rw, input logic rr,
                     input logic [3:0] rsel, input logic [7:0] rdin);
    @(negedge C7M);
    bus.AWrStb = aw; bus.ARdStb = ar; bus.ASel = asel; bus.ADin = adin;
    bus.RWrStb = rw; bus.RRdStb = rr; bus.RSel = rsel; bus.RDin = rdin;
    #1;
    a_s = bus.ADout;
    r_s = bus.RDout;
    @(posedge C7M);
    #1;
    bus.AWrStb = 1'b0; bus.ARdStb = 1'b0;
    bus.RWrStb = 1'b0; bus.RRdStb = 1'b0;
  endtask

  task automatic peek(input logic [3:0] asel, input logic [3:0] rsel);
    bus.ASel = asel;
    bus.RSel = rsel;
    #1;
    a_s = bus.ADout;
    r_s = bus.RDout;
  endtask

  task automatic a_push(input logic [7:0] d);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({1'b1, d[6:0]});
    cyc(1'b1, 1'b0, REG_CMD, d, 1'b0, 1'b0, REG_STAT, 8'h00);
  endtask

  task automatic r_pop(input string tag);
    logic [7:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    cyc(1'b0, 1'b0, REG_STAT, 8'h00, 1'b0, 1'b1, REG_CMD, 8'h00);
    check(tag, r_s, e);
  endtask

  task automatic push_pop(input logic [7:0] d, input string tag);
    logic [7:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({1'b1, d[6:0]});
    cyc(1'b1, 1'b0, REG_CMD, d, 1'b0, 1'b1, REG_CMD, 8'h00);
    check(tag, r_s, e);
  endtask

  initial begin
    bus.AWrStb = 1'b0; bus.ARdStb = 1'b0; bus.ASel = '0; bus.ADin = '0;
    bus.RWrStb = 1'b0; bus.RRdStb = 1'b0; bus.RSel = '0; bus.RDin = '0;

    // Reset state
    #12;
    peek(REG_STAT, REG_CMD);
    check("rst_status", a_s, 8'h00);
    check("rst_cmd", r_s, 8'h00);
    check("rst_airq", {7'b0, bus.AIRQ}, 8'h00);
    check("rst_nrirq", {7'b0, bus.nRIRQ}, 8'h01);
    peek(REG_DATAL, REG_DATAH);
    check("rst_datal", a_s, 8'h00);
    check("rst_datah", r_s, 8'h00);
    peek(4'd9, 4'd15);
    check("unmapped_a", a_s, 8'h00);
    check("unmapped_r", r_s, 8'h00);
    @(negedge C7M);
    nRES = 1'b1;

    // Enable both interrupts
    cyc(1'b1, 1'b0, REG_STAT, 8'h03, 1'b0, 1'b0, REG_STAT, 8'h00);
    peek(REG_STAT, REG_STAT);
    check("en_status", a_s, 8'h03);
    check("en_nrirq_empty", {7'b0, bus.nRIRQ}, 8'h01);

    // Fill past capacity, drain past empty
    a_push(8'h11); a_push(8'h22); a_push(8'h33); a_push(8'h44); a_push(8'h55);
    peek(REG_STAT, REG_STAT);
    check("ovf_status", a_s, 8'hA3);
    check("ovf_nrirq", {7'b0, bus.nRIRQ}, 8'h00);
    peek(REG_CMD, REG_STAT);
    check("full_count", a_s, 8'h04);
    for (int i = 0; i < 5; i++) r_pop("drain_pop");
    cyc(1'b1, 1'b0, REG_STAT, 8'h23, 1'b0, 1'b0, REG_STAT, 8'h00);
    peek(REG_STAT, REG_STAT);
    check("ovf_cleared", a_s, 8'h03);

    // Push and pop together while full
    a_push(8'h01); a_push(8'h02); a_push(8'h03); a_push(8'h04);
    push_pop(8'h7F, "full_pushpop");
    peek(REG_STAT, REG_STAT);
    check("full_pp_status", a_s, 8'h83);
    peek(REG_CMD, REG_STAT);
    check("full_pp_count", a_s, 8'h04);
    for (int i = 0; i < 4; i++) r_pop("after_pp_pop");
    check("last_is_ff", r_s, 8'hFF);

    // Push and pop together while empty
    push_pop(8'h05, "empty_pushpop");
    peek(REG_CMD, REG_STAT);
    check("empty_pp_count", a_s, 8'h01);
    r_pop("empty_pp_pop");
    check("empty_pp_val", r_s, 8'h85);

    // Data register collisions
    cyc(1'b1, 1'b0, REG_DATAL, 8'hAA, 1'b1, 1'b0, REG_DATAL, 8'h55);
    peek(REG_DATAL, REG_DATAL);
    check("coll_a_datal", a_s, 8'h55);
    check("coll_r_datal", r_s, 8'h55);
    peek(REG_STAT, REG_STAT);
    check("coll_status", a_s, 8'h13);
    cyc(1'b1, 1'b0, REG_STAT, 8'h13, 1'b0, 1'b0, REG_STAT, 8'h00);
    peek(REG_STAT, REG_STAT);
    check("coll_cleared", a_s, 8'h03);
    cyc(1'b1, 1'b0, REG_DATAH, 8'h12, 1'b1, 1'b0, REG_DATAL, 8'h34);
    peek(REG_DATAH, REG_DATAL);
    check("split_a_datah", a_s, 8'h12);
    check("split_r_datal", r_s, 8'h34);
    peek(REG_STAT, REG_DATAH);
    check("split_no_coll", a_s, 8'h03);
    check("split_r_datah", r_s, 8'h12);

    // Done handshake and AIRQ
    cyc(1'b0, 1'b0, REG_STAT, 8'h00, 1'b1, 1'b0, REG_STAT, 8'h01);
    check("done_airq", {7'b0, bus.AIRQ}, 8'h01);
    cyc(1'b0, 1'b1, REG_STAT, 8'h00, 1'b0, 1'b0, REG_STAT, 8'h00);
    check("done_read1", a_s, 8'h43);
    check("done_airq_clr", {7'b0, bus.AIRQ}, 8'h00);
    peek(REG_STAT, REG_STAT);
    check("done_read2", a_s, 8'h03);
    cyc(1'b0, 1'b1, REG_STAT, 8'h00, 1'b1, 1'b0, REG_STAT, 8'h01);
    check("done_setwins_rd", a_s, 8'h03);
    check("done_setwins", {7'b0, bus.AIRQ}, 8'h01);

    // Asynchronous reset mid-transfer
    a_push(8'h21); a_push(8'h22); a_push(8'h23);
    check("pre_rst_airq", {7'b0, bus.AIRQ}, 8'h01);
    check("pre_rst_nrirq", {7'b0, bus.nRIRQ}, 8'h00);
    @(negedge C7M);
    bus.AWrStb = 1'b1; bus.ASel = REG_CMD; bus.ADin = 8'h66;
    bus.RRdStb = 1'b1; bus.RSel = REG_CMD;
    #2;
    nRES = 1'b0;
    #1;
    check("rst_async_airq", {7'b0, bus.AIRQ}, 8'h00);
    check("rst_async_nrirq", {7'b0, bus.nRIRQ}, 8'h01);
    check("rst_async_cmd", bus.RDout, 8'h00);
    @(posedge C7M);
    #1;
    bus.AWrStb = 1'b0; bus.RRdStb = 1'b0;
    @(negedge C7M);
    nRES = 1'b1;
    exp_q.delete();
    r_pop("post_rst_pop");
    peek(REG_STAT, REG_STAT);
    check("post_rst_status", a_s, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
